fpdiv_issuer: RTL and testbench
===============================

// Module: fpdiv_issuer
// PURPOSE
//  Initiator side of the fpdiv operand/result interface. Queues operand pairs (IEEE-754 single),
//  presents one pair at a time on DivA/DivB, holds it stable and waits for the divider's answer.
//  Completion is a fixed latency or the divider's DONE, with a timeout. Captures AbyB/EXCEPTION
//  into a valid/ready result register. Sits between a command source and the fpdiv core.
// PARAMETERS
//  DEPTH    4   operand FIFO entries; power of 2, >=2
//  LATENCY  25  cycles from operand launch to result capture when USE_DONE=0; >=1
//  USE_DONE 0   1: completion on DivDone; 0: completion on fixed LATENCY count
//  TIMEOUT  64  max wait cycles when USE_DONE=1; must be >=LATENCY
// PORTS
//  CLOCK          in   1   single clock, rising edge
//  RESET          in   1   asynchronous, active-high
//  in_valid       in   1   operand pair offered
//  in_ready       out  1   FIFO can accept (= !full)
//  in_a           in   32  dividend
//  in_b           in   32  divisor
//  DivA           out  32  operand A to divider (InputA)
//  DivB           out  32  operand B to divider (InputB)
//  DivResult      in   32  divider quotient (AbyB)
//  DivDone        in   1   divider completion flag (DONE)
//  DivException   in   2   divider exception flags (EXCEPTION)
//  out_valid      out  1   result register full
//  out_ready      in   1   consumer accepts result
//  out_result     out  32  captured quotient
//  out_exception  out  2   captured exception flags
//  out_timeout    out  1   result captured by timeout, not by DivDone
//  busy           out  1   state != IDLE or FIFO non-empty
// BEHAVIOUR
//  - Reset (async): FIFO empty, state IDLE, counter 0. DivA, DivB, out_result = 0;
//    out_exception = 0; out_valid, out_timeout, busy = 0. in_ready = 1 once RESET deasserts.
//  - FIFO push on edge with in_valid & in_ready. Pointers wrap modulo DEPTH. Push is blocked when
//    full, even if a pop happens in the same cycle.
//  - FSM states are IDLE, WAIT and RESULT.
//  - IDLE: if FIFO non-empty, pop the head and load DivA/DivB, clear counter, go to WAIT.
//    Otherwise stay in IDLE.
//  - WAIT: DivA/DivB held constant. counter increments every edge and saturates.
//    - USE_DONE=0: capture when counter == LATENCY-1. The capture edge is the LATENCY-th
//      edge after the launch edge.
//    - USE_DONE=1: capture on the first edge with DivDone=1 and counter>=1. If no such edge
//      occurs, capture when counter == TIMEOUT-1 and set out_timeout=1.
//    - Capture loads out_result <= DivResult and out_exception <= DivException.
//      out_timeout = 0 unless the capture was a timeout. Then go to RESULT.
//  - RESULT: out_valid=1, with out_result, out_exception and out_timeout stable.
//    On an edge with out_ready=1, clear out_valid and go to IDLE.
//    No new launch happens while in RESULT (back-pressure).
//  - Throughput: one division per LATENCY+2 cycles at best. The IDLE bubble is mandatory.
//  - DivA/DivB keep their last operands after completion until the next launch.
//  - The FIFO keeps accepting pushes in every state while not full.
//  - Reset mid-operation: the in-flight op and all queued ops are discarded and no result
//    is produced.
//  - Data are passed through bit-exact. No arithmetic on operands or results.
// TESTING
//  1. USE_DONE=0, LATENCY=25: push a=0x40A00000, b=0x40000000 on edge N, DivResult model
//     returns 0x40200000. Required: out_valid rises after edge N+26, out_result=0x40200000,
//     out_timeout=0.
//  2. Fill: out_ready=0, push 6 pairs back-to-back. Required: the first launches; with DEPTH=4,
//     in_ready drops after 5 accepts (1 in flight + 4 queued). The 6th is held until
//     out_ready=1 frees a slot.
//  3. Back-pressure: hold out_ready=0 for 40 cycles after the first result. Required: out_*
//     stable, DivA/DivB unchanged, no second launch. A launch occurs 1 edge after out_ready=1.
//  4. USE_DONE=1, TIMEOUT=64: DivDone pulses at counter=3. Required: capture on that edge,
//     out_timeout=0. Repeat with DivDone tied 0: capture at counter=63, out_timeout=1.
//  5. Exception pass-through: a=0x7F800000, b=0x40000000, model DivException=2'b01,
//     DivResult=0. Required: out_exception=2'b01, out_result=0x00000000.
//  6. Assert RESET for 1 cycle mid-WAIT with 2 pairs queued. Required: all outputs 0
//     immediately, busy=0, no out_valid afterwards. A fresh push then completes normally.

Source files
------------

// File: rtl/fpdiv_issuer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fpdiv_issuer : queues FP32 operand pairs, issues them to the divider one at
//                a time and holds each result in a valid/ready register.
// Rev 1.0
// ---------------------------------------------------------------------------
module fpdiv_issuer #(
    parameter int DEPTH    = 4,
    parameter int LATENCY  = 25,
    parameter int USE_DONE = 0,
    parameter int TIMEOUT  = 64
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [31:0] DivA,
    output logic [31:0] DivB,
    input  logic [31:0] DivResult,
    input  logic        DivDone,
    input  logic [1:0]  DivException,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [1:0]  out_exception,
    output logic        out_timeout,
    output logic        busy
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = $clog2(TIMEOUT + LATENCY + 1);

    localparam logic [c_AW:0]   c_DEPTH    = (c_AW + 1)'(DEPTH);
    localparam logic [c_CW-1:0] c_LAT_LAST = c_CW'(LATENCY - 1);
    localparam logic [c_CW-1:0] c_TO_LAST  = c_CW'(TIMEOUT - 1);
    localparam logic [c_CW-1:0] c_CNT_MAX  = '1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_RESULT = 2'd2;

    logic [63:0]     r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic [1:0]      r_state;
    logic [c_CW-1:0] r_cnt;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_done_hit;
    logic w_to_hit;
    logic w_capture;

    assign w_full   = (r_count == c_DEPTH);
    assign w_empty  = (r_count == '0);
    // Full blocks the push even when a launch frees a slot on the same edge.
    assign in_ready = ~w_full & ~RESET;
    assign w_push   = in_valid & in_ready;
    assign w_pop    = (r_state == S_IDLE) & ~w_empty;
    assign busy     = (r_state != S_IDLE) | ~w_empty;

    // DivDone seen in the launch cycle itself belongs to the previous operation.
    assign w_done_hit = (USE_DONE != 0) ? (DivDone && (r_cnt != '0))
                                        : (r_cnt == c_LAT_LAST);
    assign w_to_hit   = (USE_DONE != 0) && (r_cnt == c_TO_LAST);
    assign w_capture  = (r_state == S_WAIT) & (w_done_hit | w_to_hit);

    always_ff @(posedge CLOCK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_a, in_b};
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            DivA          <= '0;
            DivB          <= '0;
            out_valid     <= 1'b0;
            out_result    <= '0;
            out_exception <= '0;
            out_timeout   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        {DivA, DivB} <= r_mem[r_rd_ptr];
                        r_cnt        <= '0;
                        r_state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != c_CNT_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (w_capture) begin
                        out_result    <= DivResult;
                        out_exception <= DivException;
                        out_timeout   <= ~w_done_hit;
                        out_valid     <= 1'b1;
                        r_state       <= S_RESULT;
                    end
                end
                S_RESULT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fpdiv_issuer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fpdiv_issuer : directed scoreboard bench for fixed-latency and DONE modes.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_fpdiv_issuer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Divider stand-in: two fixed cases plus a bit-scramble for everything else.
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h40A0_0000 && b == 32'h4000_0000) return {2'b00, 32'h4020_0000};
        if (a == 32'h7F80_0000) return {2'b01, 32'h0000_0000};
        return {2'b00, a ^ {b[15:0], b[31:16]}};
    endfunction

    logic        in_valid0 = 0, in_ready0, out_valid0, out_ready0 = 0, out_timeout0, busy0;
    logic        DivDone0 = 0;
    logic [31:0] in_a0 = 0, in_b0 = 0, DivA0, DivB0, DivResult0, out_result0;
    logic [1:0]  DivException0, out_exception0;
    logic [33:0] m0;

    logic        in_valid1 = 0, in_ready1, out_valid1, out_ready1 = 0, out_timeout1, busy1;
    logic        DivDone1 = 0;
    logic [31:0] in_a1 = 0, in_b1 = 0, DivA1, DivB1, DivResult1, out_result1;
    logic [1:0]  DivException1, out_exception1;
    logic [33:0] m1;

    assign m0 = model(DivA0, DivB0);
    assign DivResult0 = m0[31:0];
    assign DivException0 = m0[33:32];
    assign m1 = model(DivA1, DivB1);
    assign DivResult1 = m1[31:0];
    assign DivException1 = m1[33:32];

    logic [34:0] q0[$];
    logic [34:0] q1[$];

    fpdiv_issuer #(.DEPTH(4), .LATENCY(25), .USE_DONE(0), .TIMEOUT(64)) dut0 (
        .CLOCK(clk), .RESET(rst), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_a(in_a0), .in_b(in_b0), .DivA(DivA0), .DivB(DivB0),
        .DivResult(DivResult0), .DivDone(DivDone0), .DivException(DivException0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_result(out_result0),
        .out_exception(out_exception0), .out_timeout(out_timeout0), .busy(busy0)
    );

    fpdiv_issuer #(.DEPTH(4), .LATENCY(25), .USE_DONE(1), .TIMEOUT(64)) dut1 (
        .CLOCK(clk), .RESET(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a1), .in_b(in_b1), .DivA(DivA1), .DivB(DivB1),
        .DivResult(DivResult1), .DivDone(DivDone1), .DivException(DivException1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_result(out_result1),
        .out_exception(out_exception1), .out_timeout(out_timeout1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push0(input logic [31:0] a, input logic [31:0] b, output int pc);
        bit acc = 0;
        int k = 0;
        in_valid0 = 1; in_a0 = a; in_b0 = b;
        while (!acc && k < 60) begin
            acc = in_ready0;
            @(posedge clk);
            if (acc) q0.push_back({1'b0, model(a, b)});
            @(negedge clk);
            k++;
        end
        in_valid0 = 0;
        pc = cyc;
        check("push0_accept", acc, 1);
    endtask

    task automatic push1(input logic [31:0] a, input logic [31:0] b, input logic to,
                         output int pc);
        bit acc = 0;
        int k = 0;
        in_valid1 = 1; in_a1 = a; in_b1 = b;
        while (!acc && k < 60) begin
            acc = in_ready1;
            @(posedge clk);
            if (acc) q1.push_back({to, model(a, b)});
            @(negedge clk);
            k++;
        end
        in_valid1 = 0;
        pc = cyc;
        check("push1_accept", acc, 1);
    endtask

    task automatic get_result0(input string tag, output int vc);
        logic [34:0] e = '0;
        int k = 0;
        while (!out_valid0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        vc = cyc;
        check({tag, "_valid"}, out_valid0, 1);
        check({tag, "_sb_nonempty"}, q0.size() > 0, 1);
        if (q0.size() > 0) e = q0.pop_front();
        check({tag, "_result"}, out_result0, e[31:0]);
        check({tag, "_exception"}, out_exception0, e[33:32]);
        check({tag, "_timeout"}, out_timeout0, e[34]);
        out_ready0 = 1;
        @(posedge clk);
        @(negedge clk);
        out_ready0 = 0;
        check({tag, "_cleared"}, out_valid0, 0);
    endtask

    task automatic get_result1(input string tag, output int vc);
        logic [34:0] e = '0;
        int k = 0;
        while (!out_valid1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        vc = cyc;
        check({tag, "_valid"}, out_valid1, 1);
        check({tag, "_sb_nonempty"}, q1.size() > 0, 1);
        if (q1.size() > 0) e = q1.pop_front();
        check({tag, "_result"}, out_result1, e[31:0]);
        check({tag, "_exception"}, out_exception1, e[33:32]);
        check({tag, "_timeout"}, out_timeout1, e[34]);
        out_ready1 = 1;
        @(posedge clk);
        @(negedge clk);
        out_ready1 = 0;
        check({tag, "_cleared"}, out_valid1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          pc, vc, ce1, k;
        bit          ok;
        logic [31:0] ta[6];
        logic [31:0] tb[6];
        logic [31:0] sa, sb, sr;
        logic [1:0]  se;
        logic        st;

        for (int i = 0; i < 6; i++) begin
            ta[i] = 32'h3F80_0000 + (32'(i) << 16);
            tb[i] = 32'h4000_0000 + 32'(i) * 32'h0101;
        end

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid0, 0);
        check("rst_diva", DivA0, 0);
        check("rst_divb", DivB0, 0);
        check("rst_result", out_result0, 0);
        check("rst_exception", out_exception0, 0);
        check("rst_timeout", out_timeout0, 0);
        check("rst_busy", busy0, 0);
        rst = 0;
        #1;
        check("rst_in_ready", in_ready0, 1);
        @(negedge clk);

        // Fixed latency: capture on edge N+26
        push0(32'h40A0_0000, 32'h4000_0000, pc);
        check("t1_busy", busy0, 1);
        get_result0("t1", vc);
        check("t1_latency", vc - pc, 26);

        // Fill with back-pressure: 1 in flight + 4 queued
        for (int i = 0; i < 5; i++) push0(ta[i], tb[i], pc);
        check("t2_in_ready_full", in_ready0, 0);
        check("t2_first_launch_a", DivA0, ta[0]);
        check("t2_first_launch_b", DivB0, tb[0]);
        in_valid0 = 1; in_a0 = ta[5]; in_b0 = tb[5];
        k = 0;
        while (!out_valid0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        check("t3_first_valid", out_valid0, 1);
        sa = DivA0; sb = DivB0; sr = out_result0; se = out_exception0; st = out_timeout0;
        ok = 1;
        repeat (40) begin
            @(negedge clk);
            if (DivA0 !== sa || DivB0 !== sb || out_result0 !== sr || out_exception0 !== se ||
                out_timeout0 !== st || out_valid0 !== 1'b1 || in_ready0 !== 1'b0) ok = 0;
        end
        check("t3_stable_40", ok, 1);
        get_result0("t3_r1", vc);
        check("t3_no_launch_on_ack", DivA0, ta[0]);
        check("t3_still_full", in_ready0, 0);
        @(negedge clk);
        ce1 = cyc;
        check("t3_launch_a", DivA0, ta[1]);
        check("t3_launch_b", DivB0, tb[1]);
        check("t2_slot_freed", in_ready0, 1);
        @(posedge clk);
        q0.push_back({1'b0, model(ta[5], tb[5])});
        @(negedge clk);
        in_valid0 = 0;
        get_result0("t3_r2", vc);
        check("t3_r2_latency", vc - ce1, 25);
        get_result0("t2_r3", vc);
        get_result0("t2_r4", vc);
        get_result0("t2_r5", vc);
        get_result0("t2_r6", vc);
        check("t2_drained_busy", busy0, 0);

        // Exception pass-through
        push0(32'h7F80_0000, 32'h4000_0000, pc);
        get_result0("t5", vc);
        check("t5_exception_01", out_exception0, 2'b01);

        // DONE mode: pulse when the counter reads 3
        push1(32'h4120_0000, 32'h4040_0000, 1'b0, pc);
        repeat (4) @(negedge clk);
        check("t4_not_early", out_valid1, 0);
        DivDone1 = 1;
        @(negedge clk);
        DivDone1 = 0;
        check("t4_done_capture", out_valid1, 1);
        check("t4_done_cycle", cyc - pc, 5);
        get_result1("t4_done", vc);

        // DONE mode: timeout at counter 63
        push1(32'h4100_0000, 32'h3F00_0000, 1'b1, pc);
        get_result1("t4_to", vc);
        check("t4_to_latency", vc - pc, 65);

        // Reset mid-WAIT with two queued
        push0(ta[0], tb[0], pc);
        push0(ta[1], tb[1], pc);
        push0(ta[2], tb[2], pc);
        repeat (5) @(negedge clk);
        check("t6_pre_busy", busy0, 1);
        rst = 1;
        #1;
        check("t6_diva", DivA0, 0);
        check("t6_divb", DivB0, 0);
        check("t6_out_valid", out_valid0, 0);
        check("t6_busy", busy0, 0);
        check("t6_in_ready_in_reset", in_ready0, 0);
        q0.delete();
        @(negedge clk);
        rst = 0;
        #1;
        check("t6_in_ready_after", in_ready0, 1);
        ok = 1;
        repeat (40) begin
            @(negedge clk);
            if (out_valid0 !== 1'b0 || busy0 !== 1'b0) ok = 0;
        end
        check("t6_no_ghost_result", ok, 1);
        push0(32'h40A0_0000, 32'h4000_0000, pc);
        get_result0("t6_fresh", vc);
        check("t6_fresh_latency", vc - pc, 26);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
